// File: rtl/prog_chain_loader.sv
// Serialises configuration words MSB-first into a daisy-chained routing shift chain,
// generating prog_clk/prog_en and capturing the displaced contents as readback words.
module prog_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CLK_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  input  logic              chain_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] WORD_MSB = BIT_W'(WORD_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_HIGH  = 3'd3,
    S_LOW   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [BIT_W-1:0]  bit_idx_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [WORD_W-1:0] shift_r;
  logic [WORD_W-1:0] rb_shift_r;
  logic [WORD_W-1:0] shift_next_s;
  logic              busy_r;
  logic              done_r;
  logic              data_ready_r;
  logic              prog_in_r;
  logic              prog_clk_r;
  logic              prog_en_r;
  logic              rb_valid_r;
  logic [WORD_W-1:0] rb_data_r;
  logic              xfer_s;
  logic              phase_last_s;
  logic              chain_last_s;
  logic              word_last_s;
  logic              timed_s;
  logic              next_bit_s;
  logic              first_setup_s;
  logic              rb_fire_s;
  logic              prog_en_s;
  logic              cur_bit_s;

  assign xfer_s        = data_ready_r & data_valid;
  assign phase_last_s  = (div_cnt_r == DIV_LAST);
  assign chain_last_s  = (bit_cnt_r == LAST_BIT);
  assign word_last_s   = (bit_idx_r == {BIT_W{1'b0}});
  assign timed_s       = (state_r == S_SETUP) || (state_r == S_HIGH) || (state_r == S_LOW);
  assign next_bit_s    = (state_r == S_LOW) && phase_last_s && !chain_last_s;
  assign first_setup_s = (state_s == S_SETUP) && (state_r != S_SETUP);
  assign shift_next_s  = shift_r << 1'b1;
  // A readback word closes on its last bit or on the chain's last bit (partial word)
  assign rb_fire_s     = (state_r == S_HIGH) && phase_last_s && (word_last_s || chain_last_s);

  // Next-state logic plus the combinational sources of prog_en and prog_in
  always_comb begin
    state_s   = state_r;
    prog_en_s = 1'b0;
    cur_bit_s = 1'b0;
    case (state_r)
      S_IDLE:  if (start) state_s = S_FETCH; else state_s = S_IDLE;
      S_FETCH: if (xfer_s) state_s = S_SETUP; else state_s = S_FETCH;
      S_SETUP: if (phase_last_s) state_s = S_HIGH; else state_s = S_SETUP;
      S_HIGH:  if (phase_last_s) state_s = S_LOW; else state_s = S_HIGH;
      S_LOW: begin
        if (!phase_last_s)     state_s = S_LOW;
        else if (chain_last_s) state_s = S_DONE;
        else if (word_last_s)  state_s = S_FETCH;
        else                   state_s = S_SETUP;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    if (state_r == S_FETCH) cur_bit_s = data_in[WORD_W-1];
    else                    cur_bit_s = shift_next_s[WORD_W-1];
    case (state_s)
      S_SETUP, S_HIGH, S_LOW: prog_en_s = 1'b1;
      S_FETCH:                prog_en_s = prog_en_r;
      default:                prog_en_s = 1'b0;
    endcase
  end

  // State register, phase/bit counters and the data/readback shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      bit_cnt_r  <= {CNT_W{1'b0}};
      bit_idx_r  <= {BIT_W{1'b0}};
      div_cnt_r  <= {DIV_W{1'b0}};
      shift_r    <= {WORD_W{1'b0}};
      rb_shift_r <= {WORD_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_s != state_r) div_cnt_r <= {DIV_W{1'b0}};
      else if (timed_s)       div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
      if ((state_r == S_IDLE) && start) bit_cnt_r <= {CNT_W{1'b0}};
      else if (next_bit_s)              bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
      if (xfer_s) begin
        shift_r   <= data_in;
        bit_idx_r <= WORD_MSB;
      end else if (next_bit_s && !word_last_s) begin
        shift_r   <= shift_next_s;
        bit_idx_r <= bit_idx_r - BIT_W'(1'b1);
      end
      if ((state_r == S_SETUP) && phase_last_s)
        rb_shift_r <= (rb_shift_r << 1'b1) | WORD_W'(chain_out);
    end
  end

  // Output registers, all derived from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      data_ready_r <= 1'b0;
      prog_in_r    <= 1'b0;
      prog_clk_r   <= 1'b0;
      prog_en_r    <= 1'b0;
      rb_valid_r   <= 1'b0;
      rb_data_r    <= {WORD_W{1'b0}};
    end else begin
      busy_r       <= (state_s != S_IDLE);
      done_r       <= (state_s == S_DONE);
      data_ready_r <= (state_s == S_FETCH);
      prog_clk_r   <= (state_s == S_HIGH);
      prog_en_r    <= prog_en_s;
      if (first_setup_s) prog_in_r <= cur_bit_s;
      rb_valid_r   <= rb_fire_s;
      // Unfilled low bits of a partial final word come out as zeros
      if (rb_fire_s) rb_data_r <= rb_shift_r << bit_idx_r;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign data_ready = data_ready_r;
  assign prog_in    = prog_in_r;
  assign prog_clk   = prog_clk_r;
  assign prog_en    = prog_en_r;
  assign rb_valid   = rb_valid_r;
  assign rb_data    = rb_data_r;

endmodule

// File: tb/tb_prog_chain_loader.sv
// Directed bench for prog_chain_loader: three instances (4-bit mux chain, 10-bit loopback,
// CLK_DIV=3) with behavioural chain models hanging off prog_in/prog_clk/prog_en.
module tb_prog_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   num_checks = 0;
  int   num_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit A: CHAIN_LEN=4, WORD_W=4, CLK_DIV=1 driving one 16:1 mux select
  logic        a_start = 1'b0, a_valid = 1'b0;
  logic [3:0]  a_data = 4'h0;
  logic        a_busy, a_done, a_ready, a_pin, a_pclk, a_pen, a_cout, a_rbv;
  logic [3:0]  a_rb;
  logic [3:0]  a_chain = 4'h0;
  logic [15:0] a_mux_in = 16'h0000;
  logic        a_mux_out;
  assign a_cout    = a_chain[3];
  assign a_mux_out = a_mux_in[a_chain];

  prog_chain_loader #(.CHAIN_LEN(4), .WORD_W(4), .CLK_DIV(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .data_in(a_data), .data_valid(a_valid), .data_ready(a_ready),
    .prog_in(a_pin), .prog_clk(a_pclk), .prog_en(a_pen), .chain_out(a_cout),
    .rb_data(a_rb), .rb_valid(a_rbv));

  always @(posedge a_pclk) if (a_pen) a_chain <= {a_chain[2:0], a_pin};

  int         a_rises = 0, a_last_rise = -1, a_dones = 0, a_done_cyc = 0, a_rbv_cyc = 0;
  int         a_gaps[$];
  logic [3:0] a_rbs[$];
  logic       a_pclk_q = 1'b0;
  always @(negedge clk) begin
    if (a_pclk && !a_pclk_q) begin
      if (a_last_rise >= 0) a_gaps.push_back(cyc - a_last_rise);
      a_last_rise = cyc;
      a_rises++;
    end
    a_pclk_q = a_pclk;
    if (a_done) begin a_dones++; a_done_cyc = cyc; end
    if (a_rbv) begin a_rbs.push_back(a_rb); a_rbv_cyc = cyc; end
  end

  // Unit B: CHAIN_LEN=10, WORD_W=4 loopback chain
  logic       b_start = 1'b0, b_valid = 1'b0;
  logic [3:0] b_data = 4'h0;
  logic       b_busy, b_done, b_ready, b_pin, b_pclk, b_pen, b_cout, b_rbv;
  logic [3:0] b_rb;
  logic [9:0] b_chain = 10'h000;
  assign b_cout = b_chain[9];

  prog_chain_loader #(.CHAIN_LEN(10), .WORD_W(4), .CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .data_in(b_data), .data_valid(b_valid), .data_ready(b_ready),
    .prog_in(b_pin), .prog_clk(b_pclk), .prog_en(b_pen), .chain_out(b_cout),
    .rb_data(b_rb), .rb_valid(b_rbv));

  always @(posedge b_pclk) if (b_pen) b_chain <= {b_chain[8:0], b_pin};

  int         b_rises = 0, b_dones = 0;
  logic [3:0] b_rbs[$];
  logic       b_pclk_q = 1'b0;
  always @(negedge clk) begin
    if (b_pclk && !b_pclk_q) b_rises++;
    b_pclk_q = b_pclk;
    if (b_done) b_dones++;
    if (b_rbv) b_rbs.push_back(b_rb);
  end

  // Unit C: CHAIN_LEN=4, WORD_W=4, CLK_DIV=3
  logic       c_start = 1'b0, c_valid = 1'b0;
  logic [3:0] c_data = 4'h0;
  logic       c_busy, c_done, c_ready, c_pin, c_pclk, c_pen, c_cout, c_rbv;
  logic [3:0] c_rb;
  logic [3:0] c_chain = 4'h0;
  assign c_cout = c_chain[3];

  prog_chain_loader #(.CHAIN_LEN(4), .WORD_W(4), .CLK_DIV(3)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
    .data_in(c_data), .data_valid(c_valid), .data_ready(c_ready),
    .prog_in(c_pin), .prog_clk(c_pclk), .prog_en(c_pen), .chain_out(c_cout),
    .rb_data(c_rb), .rb_valid(c_rbv));

  always @(posedge c_pclk) if (c_pen) c_chain <= {c_chain[2:0], c_pin};

  int   c_hi_run = 0, c_pin_run = 0, c_dones = 0;
  int   c_hi_runs[$], c_pin_runs[$];
  logic c_pin_q = 1'b0;
  always @(negedge clk) begin
    if (c_pclk) c_hi_run++;
    else if (c_hi_run > 0) begin c_hi_runs.push_back(c_hi_run); c_hi_run = 0; end
    if (c_pin != c_pin_q) begin c_pin_runs.push_back(c_pin_run); c_pin_run = 1; end
    else c_pin_run++;
    c_pin_q = c_pin;
    if (c_done) c_dones++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_of(input int u);
    case (u)
      0:       return a_ready;
      1:       return b_ready;
      default: return c_ready;
    endcase
  endfunction

  function automatic logic [2:0] hold_of(input int u);
    case (u)
      0:       return {a_pclk, a_pen, a_ready};
      1:       return {b_pclk, b_pen, b_ready};
      default: return {c_pclk, c_pen, c_ready};
    endcase
  endfunction

  function automatic int dones_of(input int u);
    case (u)
      0:       return a_dones;
      1:       return b_dones;
      default: return c_dones;
    endcase
  endfunction

  task automatic set_word(input int u, input logic [3:0] w, input logic v);
    case (u)
      0:       begin a_data = w; a_valid = v; end
      1:       begin b_data = w; b_valid = v; end
      default: begin c_data = w; c_valid = v; end
    endcase
  endtask

  task automatic set_start(input int u, input logic v);
    case (u)
      0:       a_start = v;
      1:       b_start = v;
      default: c_start = v;
    endcase
  endtask

  task automatic pulse_start(input int u);
    @(negedge clk);
    set_start(u, 1'b1);
    @(negedge clk);
    set_start(u, 1'b0);
  endtask

  // Waits for data_ready, optionally stalls with valid low, then transfers one word
  task automatic drive_word(input int u, input logic [3:0] w, input int stall);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_of(u) && t < 500) begin @(negedge clk); t++; end
    check_eq("ready_timeout", (t < 500) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_hold", hold_of(u), 3'b011);
    end
    set_word(u, w, 1'b1);
    @(negedge clk);
    set_word(u, w, 1'b0);
  endtask

  task automatic wait_done(input int u, input int base);
    int t;
    t = 0;
    while (dones_of(u) == base && t < 2000) begin @(negedge clk); t++; end
    check_eq("done_timeout", (t < 2000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nr, nrb, np;
    logic [3:0] rb_exp [0:2];

    // Reset state
    repeat (4) @(negedge clk);
    check_eq("rst_a_out", {a_busy, a_done, a_ready, a_pin, a_pclk, a_pen, a_rbv, a_rb}, 32'd0);
    check_eq("rst_b_out", {b_busy, b_ready, b_pclk, b_pen, b_rbv, b_rb}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A: first load of 4'hA into an all-zero chain
    base = a_dones; nr = a_rises; nrb = a_rbs.size();
    pulse_start(0);
    check_eq("a1_busy", a_busy, 1'b1);
    drive_word(0, 4'hA, 0);
    wait_done(0, base);
    repeat (3) @(negedge clk);
    check_eq("a1_pulses", a_rises - nr, 4);
    for (int i = 1; i <= 3; i++) check_eq("a1_gap", a_gaps[a_gaps.size() - i], 3);
    check_eq("a1_done_lat", a_done_cyc - a_last_rise, 2);
    check_eq("a1_rbv_lat", a_rbv_cyc - a_last_rise, 1);
    check_eq("a1_chain", a_chain, 4'hA);
    check_eq("a1_rb_cnt", a_rbs.size() - nrb, 1);
    check_eq("a1_rb", a_rbs[a_rbs.size() - 1], 4'h0);
    check_eq("a1_idle", {a_busy, a_pen, a_pclk, a_ready}, 4'h0);
    a_mux_in = 16'h0400; #1;
    check_eq("a1_mux_hi", a_mux_out, 1'b1);
    a_mux_in = ~16'h0400; #1;
    check_eq("a1_mux_lo", a_mux_out, 1'b0);

    // A: reload with 4'h5, old contents come back
    base = a_dones; nr = a_rises; nrb = a_rbs.size();
    pulse_start(0);
    drive_word(0, 4'h5, 0);
    wait_done(0, base);
    repeat (3) @(negedge clk);
    check_eq("a2_pulses", a_rises - nr, 4);
    check_eq("a2_rb_cnt", a_rbs.size() - nrb, 1);
    check_eq("a2_rb", a_rbs[a_rbs.size() - 1], 4'hA);
    check_eq("a2_chain", a_chain, 4'h5);
    a_mux_in = 16'h0020; #1;
    check_eq("a2_mux_hi", a_mux_out, 1'b1);
    a_mux_in = 16'h0400; #1;
    check_eq("a2_mux_lo", a_mux_out, 1'b0);

    // B: 10-bit loopback, words F,0,C with a 10-cycle stall before the second word
    base = b_dones; nr = b_rises; nrb = b_rbs.size();
    pulse_start(1);
    drive_word(1, 4'hF, 0);
    drive_word(1, 4'h0, 10);
    drive_word(1, 4'hC, 0);
    wait_done(1, base);
    repeat (3) @(negedge clk);
    check_eq("b1_pulses", b_rises - nr, 10);
    check_eq("b1_chain", b_chain, 10'b1111000011);
    check_eq("b1_rb_cnt", b_rbs.size() - nrb, 3);
    for (int i = 0; i < 3; i++) check_eq("b1_rb", b_rbs[nrb + i], 4'h0);

    // B: second load 3,5,8 reads back F,0,C (partial word left-aligned)
    base = b_dones; nr = b_rises; nrb = b_rbs.size();
    rb_exp[0] = 4'hF; rb_exp[1] = 4'h0; rb_exp[2] = 4'hC;
    pulse_start(1);
    drive_word(1, 4'h3, 0);
    drive_word(1, 4'h5, 0);
    drive_word(1, 4'h8, 0);
    wait_done(1, base);
    repeat (3) @(negedge clk);
    check_eq("b2_pulses", b_rises - nr, 10);
    check_eq("b2_chain", b_chain, 10'b0011010110);
    check_eq("b2_rb_cnt", b_rbs.size() - nrb, 3);
    for (int i = 0; i < 3; i++) check_eq("b2_rb", b_rbs[nrb + i], rb_exp[i]);

    // C: CLK_DIV=3 phase lengths
    base = c_dones; nr = c_hi_runs.size(); np = c_pin_runs.size();
    pulse_start(2);
    drive_word(2, 4'hA, 0);
    wait_done(2, base);
    repeat (4) @(negedge clk);
    check_eq("c_pulses", c_hi_runs.size() - nr, 4);
    for (int i = 1; i <= 4; i++) check_eq("c_hi_len", c_hi_runs[c_hi_runs.size() - i], 3);
    check_eq("c_pin_changes", c_pin_runs.size() - np, 4);
    for (int i = 1; i <= 3; i++) check_eq("c_pin_len", c_pin_runs[c_pin_runs.size() - i], 9);
    check_eq("c_chain", c_chain, 4'hA);

    // A: reset during the second bit of a 4'hC load
    nr = a_rises;
    pulse_start(0);
    drive_word(0, 4'hC, 0);
    np = 0;
    while (a_rises - nr < 2 && np < 200) begin @(negedge clk); np++; end
    check_eq("rst_wait_timeout", (np < 200) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_out", {a_busy, a_done, a_ready, a_pin, a_pclk, a_pen, a_rbv, a_rb}, 32'd0);
    rst = 1'b0;
    nr = a_rises;
    repeat (10) @(negedge clk);
    check_eq("rst_no_pclk", a_rises - nr, 0);
    check_eq("rst_chain", a_chain, 4'h7);

    // A: full load after the abort, with a start pulse while busy
    base = a_dones; nrb = a_rbs.size();
    pulse_start(0);
    drive_word(0, 4'hA, 0);
    pulse_start(0);
    wait_done(0, base);
    repeat (12) @(negedge clk);
    check_eq("a3_done_cnt", a_dones - base, 1);
    check_eq("a3_idle", {a_busy, a_ready}, 2'b00);
    check_eq("a3_chain", a_chain, 4'hA);
    check_eq("a3_rb_cnt", a_rbs.size() - nrb, 1);
    check_eq("a3_rb", a_rbs[a_rbs.size() - 1], 4'h7);
    a_mux_in = 16'h0400; #1;
    check_eq("a3_mux_hi", a_mux_out, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/prog_chain_loader.md
Name: prog_chain_loader

Overview:
Configuration-chain driver that sits directly upstream of the programmable-routing shift chain (prog_mux16 instances daisy-chained via prog_in/prog_out). It accepts configuration words over a valid/ready handshake and serializes them MSB-first onto prog_in. It generates the gated prog_clk and prog_en for the chain, and captures the bits returning from the chain tail as readback words.

Parameters:
CHAIN_LEN, 64, total configuration bits in the chain (>=1; need not be a multiple of WORD_W)
WORD_W, 8, width of input and readback words
CLK_DIV, 1, clk cycles per prog_clk phase (>=1); one bit takes 3*CLK_DIV cycles

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a full chain load; ignored unless IDLE
busy  output  1  high from the cycle after an accepted start until DONE is left
done  output  1  one-cycle pulse when the last bit has been clocked in
data_in  input  WORD_W  next configuration word, MSB shifted first
data_valid  input  1  data_in valid
data_ready  output  1  loader accepts data_in this cycle (transfer = valid & ready)
prog_in  output  1  serial config bit to chain head
prog_clk  output  1  chain shift clock (generated, registered)
prog_en  output  1  chain shift enable
chain_out  input  1  prog_out of chain tail (previous contents emerging)
rb_data  output  WORD_W  readback word of old chain contents
rb_valid  output  1  one-cycle pulse, rb_data valid

Behaviour:
- Reset: busy, done, data_ready, prog_in, prog_clk, prog_en, rb_valid = 0; rb_data = 0; FSM -> IDLE; counters cleared. Reset mid-load aborts immediately; the chain is left partially shifted; prog_clk drops to 0 on that edge with no further edges.
- States: IDLE, FETCH, SETUP, HIGH, LOW, DONE. All outputs are registered.
- IDLE: start=1 -> FETCH; bit counter = 0.
- FETCH: data_ready=1. On transfer, latch data_in into shift reg, bit-in-word = WORD_W-1 -> SETUP. While valid is low: stall, prog_en held, prog_clk=0.
- SETUP (CLK_DIV cycles): prog_en=1, prog_in = current bit, prog_clk=0. On the last SETUP cycle, sample chain_out into the readback shift register (MSB-first) -> HIGH.
- HIGH (CLK_DIV cycles): prog_clk=1, prog_in stable -> LOW.
- LOW (CLK_DIV cycles): prog_clk=0, then:
  - if bit counter == CHAIN_LEN-1 -> DONE;
  - else if word exhausted -> FETCH;
  - else next bit -> SETUP.
- Setup/hold: prog_in changes only in the first SETUP cycle. It is stable through HIGH and LOW.
- Final partial word: when CHAIN_LEN mod WORD_W = r != 0, only the r MSBs of the last word are shifted. Its LSBs are discarded.
- Readback: rb_valid pulses for one cycle, in the cycle after the HIGH that follows sampling bit WORD_W-1 of a word, or the chain's final bit. A partial final readback word is left-aligned with zero LSBs. The readback word count equals the input word count.
- DONE: one cycle; done=1, prog_en=0, busy=0 on the next cycle -> IDLE.
- busy=1 in FETCH..DONE. A start while busy has no effect.
- Bit counter width: clog2(CHAIN_LEN). The counter never wraps within a load.

Test Plan:
- CHAIN_LEN=4, WORD_W=4, CLK_DIV=1, feeding one prog_mux16. Reset, start, send 4'hA -> prog_clk shows 4 pulses, 3 cycles/bit; prog_in sequence 1,0,1,0; done after the 4th LOW; then in=16'h0400 -> out=1, and in=~16'h0400 -> out=0.
- Same setup: reload with 4'h5 -> rb_data=4'hA with a single rb_valid pulse; mux then selects in[5].
- data_valid held low for 10 cycles in FETCH -> prog_clk stays 0, prog_en stays 1, no bit lost; the final chain contents are still correct.
- CHAIN_LEN=10, WORD_W=4, loopback (chain_out modelled by a 10-bit shift register). Send 4'hF, 4'h0, 4'hC -> 10 prog_clk pulses; model = 10'b1111000011; the third word's two LSBs are ignored; rb_valid pulses 3 times.
- CLK_DIV=3 -> each prog_clk high phase lasts 3 clk cycles, and prog_in is stable for 9 cycles per bit.
- Assert rst during bit 2 of a load -> next edge all outputs 0; a subsequent start and full load complete normally; start pulsed while busy is ignored (a single done pulse).
